// File: rtl/dsp_accum_stage.sv
// Registered accumulator behind the 2-bit multiply/divide DSP cell: sums BURST_LEN beats per result.
// Optional clamp-at-max arithmetic is enabled with `define DSP_ACCUM_SATURATE_EN (wrap-around otherwise).
module dsp_accum_stage #(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_mode,
    input  logic                  in_err,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_acc,
    output logic                  out_err,
    output logic                  out_mixed,
    output logic                  out_sat
);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] LAST_CNT = 8'(BURST_LEN - 1);

    state_t                 state, state_next;
    logic                   accept;
    logic                   last_beat;
    logic [7:0]             cnt_p0;
    logic [ACC_WIDTH-1:0]   acc_p0;
    logic                   err_p0;
    logic                   mixed_p0;
    logic                   mode_p0;
    logic [ACC_WIDTH-1:0]   addend;
    logic [ACC_WIDTH-1:0]   sum_next;
    logic                   err_next;
    logic                   mixed_next;
    logic [ACC_WIDTH-1:0]   acc_p1;
    logic                   err_p1;
    logic                   mixed_p1;

    assign accept     = in_valid && in_ready;
    assign last_beat  = (cnt_p0 == LAST_CNT);
    assign addend     = in_err ? '0 : ACC_WIDTH'(in_data);
    assign err_next   = err_p0 | in_err;
    // The first beat of a burst only latches the mode; later beats compare against it.
    assign mixed_next = mixed_p0 | ((cnt_p0 != 8'd0) && (in_mode != mode_p0));

`ifdef DSP_ACCUM_SATURATE_EN
    logic sat_hit;
    logic sat_p0;
    logic sat_p1;

    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        if (wide[ACC_WIDTH]) sat_add = {1'b1, {ACC_WIDTH{1'b1}}};
        else                 sat_add = wide;
    endfunction

    assign {sat_hit, sum_next} = sat_add(acc_p0, addend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_p0 <= 1'b0;
            sat_p1 <= 1'b0;
        end else if (clear) begin
            sat_p0 <= 1'b0;
            sat_p1 <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                sat_p1 <= sat_p0 | sat_hit;
                sat_p0 <= 1'b0;
            end else begin
                sat_p0 <= sat_p0 | sat_hit;
            end
        end
    end

    assign out_sat = sat_p1;
`else
    function automatic logic [ACC_WIDTH-1:0] wrap_add(input logic [ACC_WIDTH-1:0] a,
                                                      input logic [ACC_WIDTH-1:0] b);
        wrap_add = a + b;
    endfunction

    assign sum_next = wrap_add(acc_p0, addend);
    assign out_sat  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear)                             state_next = ACCUM;
        else if (accept && last_beat)          state_next = HOLD;
        else if (state == HOLD && out_ready)   state_next = ACCUM;
    end

    // In HOLD the input side only moves when the result is being taken in the same cycle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: in_ready = !clear;
            HOLD: begin
                in_ready  = out_ready && !clear;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // ---- p0: running burst state / p1: presented result ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0   <= '0;
            cnt_p0   <= 8'd0;
            err_p0   <= 1'b0;
            mixed_p0 <= 1'b0;
            mode_p0  <= 1'b0;
            acc_p1   <= '0;
            err_p1   <= 1'b0;
            mixed_p1 <= 1'b0;
        end else if (clear) begin
            acc_p0   <= '0;
            cnt_p0   <= 8'd0;
            err_p0   <= 1'b0;
            mixed_p0 <= 1'b0;
            mode_p0  <= 1'b0;
            acc_p1   <= '0;
            err_p1   <= 1'b0;
            mixed_p1 <= 1'b0;
        end else if (accept) begin
            if (cnt_p0 == 8'd0) mode_p0 <= in_mode;
            if (last_beat) begin
                acc_p1   <= sum_next;
                err_p1   <= err_next;
                mixed_p1 <= mixed_next;
                acc_p0   <= '0;
                cnt_p0   <= 8'd0;
                err_p0   <= 1'b0;
                mixed_p0 <= 1'b0;
            end else begin
                acc_p0   <= sum_next;
                cnt_p0   <= cnt_p0 + 8'd1;
                err_p0   <= err_next;
                mixed_p0 <= mixed_next;
            end
        end
    end

    assign out_acc   = acc_p1;
    assign out_err   = err_p1;
    assign out_mixed = mixed_p1;

endmodule

// File: doc/dsp_accum_stage.md
Name: dsp_accum_stage

Overview:
- Registered accumulator stage directly downstream of the 2-bit multiply/divide combinational DSP cell.
- Consumes its 4-bit result (plus mode bit and a divide-by-zero flag computed by the wrapper) one beat at a time over a valid/ready handshake.
- Sums BURST_LEN beats into an ACC_WIDTH accumulator and presents the total on an output valid/ready port.
- Gives the DSP test designs a clocked consumer, so V2X timing on the combinational cell's outputs is exercised.

Parameters:
- DATA_WIDTH, 4, width of incoming DSP result (matches combinational cell output).
- ACC_WIDTH, 8, accumulator/result width; must be >= DATA_WIDTH.
- BURST_LEN, 4, beats per accumulated result; legal range 1..255.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  DATA_WIDTH  DSP result (a*b or a/b).
- in_mode  input  1  DSP mode bit of this beat (1 = multiply, 0 = divide).
- in_err  input  1  beat is a divide with b==0; in_data is don't-care.
- clear  input  1  synchronous flush.
- out_valid  output  1  accumulated result available.
- out_ready  input  1  downstream accepts result.
- out_acc  output  ACC_WIDTH  accumulated sum.
- out_err  output  1  at least one beat in the burst had in_err.
- out_mixed  output  1  burst contained both multiply and divide beats.
- out_sat  output  1  saturation occurred (see Optional Feature); constant 0 when feature is off.

Behaviour:
- Reset (rst_n low, async): state=ACCUM, acc=0, beat count=0, sticky flags=0. Outputs: out_valid=0, out_acc=0, out_err=0, out_mixed=0, out_sat=0, in_ready=1 after release.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid && in_ready. On accept:
    - acc += zero-extended in_data, or += 0 if in_err.
    - err |= in_err.
    - First beat of a burst latches in_mode. Each later beat sets mixed if its in_mode differs from the latched mode.
    - count increments.
  - When the accepted beat is beat BURST_LEN:
    - Final sum and flags (including that beat) load into out_* registers.
    - Next state is HOLD, so out_valid rises the following cycle. Latency: last accept at cycle N -> out_valid at N+1.
    - Internal acc/count/flags return to 0.
- State HOLD:
  - out_valid=1 and out_* are stable until the handshake.
  - in_ready = out_ready (combinational pass-through).
  - out_valid && out_ready -> ACCUM next cycle. A beat offered in that same cycle is accepted as beat 1 of the next burst, so no bubble.
  - If BURST_LEN==1 and that beat is the only one, state stays HOLD and out_* reload with the new beat.
  - out_ready low -> hold indefinitely, in_ready=0, no accepts.
- Arithmetic: acc is ACC_WIDTH bits; by default overflow wraps modulo 2^ACC_WIDTH.
- clear:
  - Has priority over any handshake in the same cycle.
  - Zeroes acc/count/flags, drops out_valid, goes to ACCUM next cycle.
  - A beat presented that cycle is not accepted (in_ready forced 0 while clear=1).
- Reset mid-burst or mid-HOLD discards all partial state; no result is emitted for the partial burst.
- in_data/in_mode/in_err are sampled only on accept; X on them while in_valid=0 must not propagate.

Optional Feature:
- Macro: DSP_ACCUM_SATURATE_EN.
- Defined: additions clamp at 2^ACC_WIDTH-1. Clamping sets a sticky sat flag for the burst, reported on out_sat with the result.
- Undefined: wrap-around arithmetic; out_sat tied to 0; no saturation logic synthesized.

Test Plan:
- Basic burst: defaults, beats 9,6,4,1 with in_mode=1 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, out_acc=20, out_err=0, out_mixed=0.
- Overflow with ACC_WIDTH=5, four beats of 15 (sum 60):
  - Macro undefined -> out_acc=28, out_sat=0.
  - Macro defined -> out_acc=31, out_sat=1.
- Backpressure: complete a burst, hold out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, out_acc stable. Raise out_ready -> beat accepted that cycle counts as beat 1 of next burst, and next result reflects it.
- Error/mixed: beats (3,m=1),(X,err=1,m=0),(2,m=0),(1,m=1) -> out_acc=6, out_err=1, out_mixed=1.
- Reset mid-burst: accept 2 beats, pulse rst_n low asynchronously mid-cycle -> outputs 0 immediately. Then 4 beats of 1 -> out_acc=4 (no carry-over).
- Clear: assert clear in HOLD with out_ready=1 and in_valid=1 -> out_valid=0 next cycle, no beat accepted that cycle, next burst starts from 0.
